// File: rtl/add_round_key_stream.sv
// AES AddRoundKey stage with a valid/ready stream interface and an in-order output FIFO.
// The round key is either supplied per beat or sequenced by an internal round counter.
module add_round_key_stream #(
  parameter int NR         = 10,
  parameter int AUTO_ROUND = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [128*(NR+1)-1:0] expanded_key,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_state,
  input  logic [3:0]            in_round,
  input  logic                  round_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_state,
  output logic [3:0]            out_round,
  output logic                  round_err
);

  localparam logic [3:0] NR_L    = 4'(NR);
  localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);
  localparam logic [2:0] LAST    = 3'(FIFO_DEPTH - 1);

  // Storage is sized for the largest legal depth so 3-bit pointers index it exactly.
  logic [127:0] mem_state [0:7];
  logic [3:0]   mem_round [0:7];
  logic [2:0]   wr_ptr;
  logic [2:0]   rd_ptr;
  logic [3:0]   count;
  logic [3:0]   round_cnt;

  logic         push;
  logic         pop;
  logic [3:0]   round_sel;
  logic [127:0] key_sel;
  logic         bad_round;

  assign out_valid = (count != 4'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count < DEPTH_L) || pop;
  assign push      = in_valid && in_ready;

  always_comb begin
    round_sel = in_round;
    if (AUTO_ROUND != 0) begin
      round_sel = round_clr ? 4'd0 : round_cnt;
    end
  end

  assign bad_round = (round_sel > NR_L);

  // Out-of-range indices match no slice, leaving an all-zero key.
  always_comb begin
    key_sel = '0;
    for (int r = 0; r <= NR; r++) begin
      if (round_sel == 4'(r)) begin
        key_sel = expanded_key[128*r +: 128];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_state[wr_ptr] <= in_state ^ key_sel;
      mem_round[wr_ptr] <= round_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? 3'd0 : wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? 3'd0 : rd_ptr + 3'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt <= 4'd0;
      round_err <= 1'b0;
    end else begin
      if (AUTO_ROUND != 0) begin
        if (push) begin
          round_cnt <= (round_sel == NR_L) ? 4'd0 : round_sel + 4'd1;
        end else if (round_clr) begin
          round_cnt <= 4'd0;
        end
      end
      if (push && bad_round) begin
        round_err <= 1'b1;
      end
    end
  end

  // Gated so the outputs read zero whenever the buffer is empty, including during reset.
  assign out_state = out_valid ? mem_state[rd_ptr] : '0;
  assign out_round = out_valid ? mem_round[rd_ptr] : 4'd0;

endmodule

// File: doc/add_round_key_stream.md
ADD_ROUND_KEY_STREAM -- requirements
Module: add_round_key_stream

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; legal values 10, 12, 14 (AES-128/192/256).
REQ-002 Parameter AUTO_ROUND, default 0; 0 = round index taken from in_round, 1 = round index from internal counter.
REQ-003 Parameter FIFO_DEPTH, default 2, output buffer entries; legal values 1 to 8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 expanded_key  input  128*(NR+1)  key schedule; round r key = bits [128*r+127 : 128*r], so round 0 = bits [127:0]; static while in_valid is high.
REQ-007 in_valid  input  1  in_state, in_round are valid.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 in_state  input  128  state to be keyed.
REQ-010 in_round  input  4  round index, used only when AUTO_ROUND=0.
REQ-011 round_clr  input  1  synchronous clear of internal round counter.
REQ-012 out_valid  output  1  out_state, out_round are valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_state  output  128  in_state XOR selected round key.
REQ-015 out_round  output  4  round index applied to this beat.
REQ-016 round_err  output  1  sticky flag: a beat with round index > NR was accepted.

Function
REQ-017 Input handshake SHALL complete on a rising edge with in_valid=1 and in_ready=1; output handshake with out_valid=1 and out_ready=1.
REQ-018 Each accepted beat SHALL be computed (XOR with selected key) and written into an in-order FIFO of FIFO_DEPTH entries on the accepting edge.
REQ-019 Latency SHALL be 1 cycle: a beat accepted at edge N into an empty FIFO SHALL appear with out_valid=1 after edge N.
REQ-020 in_ready SHALL equal (occupancy < FIFO_DEPTH) OR (occupancy = FIFO_DEPTH AND out_ready=1 AND out_valid=1); push and pop on the same edge SHALL keep occupancy unchanged.
REQ-021 out_valid SHALL equal (occupancy > 0); out_state/out_round SHALL reflect the oldest entry and stay stable while out_valid=1 and out_ready=0.
REQ-022 Beats SHALL exit in acceptance order; no beat dropped or duplicated.
REQ-023 AUTO_ROUND=1: counter SHALL start at 0, select the key for each accepted beat, then increment; after a beat using round NR it SHALL wrap to 0.
REQ-024 AUTO_ROUND=1, round_clr=1 with an accept on the same edge: the beat SHALL use round 0 and counter SHALL become 1; round_clr without accept: counter becomes 0.
REQ-025 AUTO_ROUND=0: round_clr SHALL have no effect; key selected by in_round.
REQ-026 Round index > NR (only possible with AUTO_ROUND=0): key SHALL be treated as all-zero (state passes unchanged), out_round SHALL carry the index, round_err SHALL set on that edge and remain 1 until reset.
REQ-027 in_valid low SHALL never change FIFO contents, counter, or round_err.

Reset
REQ-028 rst_n low SHALL immediately clear: occupancy 0, out_valid 0, round counter 0, round_err 0; out_state and out_round SHALL read 0.
REQ-029 in_ready SHALL be 1 while rst_n is low and after release; no beat SHALL be accepted while rst_n is low.
REQ-030 Reset asserted mid-stream SHALL discard all buffered beats; first beat after release SHALL use round 0 when AUTO_ROUND=1.

Verification
REQ-031 NR=10, AUTO_ROUND=0, in_state=00112233445566778899aabbccddeeff, round 0 key=000102030405060708090a0b0c0d0e0f, out_ready=1 -> next cycle out_state=00102030405060708090a0b0c0d0e0f0, out_round=0.
REQ-032 AUTO_ROUND=1, NR=10, 12 consecutive beats, out_ready=1 -> out_round sequence 0..10,0; each out_state = in_state XOR matching key slice.
REQ-033 FIFO_DEPTH=2, out_ready=0, 3 beats offered -> first 2 accepted, in_ready=0 at third; raise out_ready -> third accepted on the pop edge; order preserved.
REQ-034 AUTO_ROUND=0, in_round=15, NR=10 -> out_state=in_state, out_round=15, round_err=1 and stays 1 through later legal beats until rst_n pulse.
REQ-035 AUTO_ROUND=1, 3 beats buffered, counter=3, rst_n pulsed low -> out_valid=0 immediately, round_err=0; next accepted beat gets out_round=0.
REQ-036 AUTO_ROUND=1, counter=5, round_clr=1 with accepted beat -> that beat out_round=0, following beat out_round=1.
